// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage feeding the control unit / decode. Owns the program counter,
// issues single-word reads to program memory over a req/ack handshake (one
// request outstanding, no prefetch) and presents each fetched word with its PC
// on a valid/ready interface. Redirects from execute discard wrong-path data.
//
// Ports:
//   clk, rst_n            system clock (rising edge), async active-low reset
//   redirect_valid/_pc    one-cycle redirect pulse and its target
//   imem_req/_addr        read request and word address to program memory
//   imem_ack/_rdata       read completion and instruction word
//   instr_valid/_ready    instruction handshake towards decode
//   instr, instr_pc       presented instruction and its PC
//   fetch_err             sticky: memory did not ack within TIMEOUT_CYCLES
//   misalign_err          sticky: misaligned redirect target trapped
//
// Build option FETCH_MISALIGN_TRAP_EN:
//   defined   - a redirect target with [1:0] != 0 sets misalign_err and parks
//               the unit in ERR (after draining any outstanding request).
//   undefined - redirect targets are forced word-aligned; misalign_err is 0.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
   parameter int                    TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [31:0]           imem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [31:0]           instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  fetch_err,
   output logic                  misalign_err
);

   // state | meaning
   // ------+----------------------------------------------------------------
   // IDLE  | no request; one-cycle gap before issuing at pc
   // REQ   | request at pc outstanding, address held until ack
   // HOLD  | instruction presented, waiting for decode to take it
   // FLUSH | wrong-path request draining; pend_pc is the next fetch target
   // ERR   | timeout or misalign trap; only rst_n leaves this state
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_HOLD  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [31:0]       NOP      = 32'h0000_0013;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   pc, pc_nxt;
   logic [ADDR_WIDTH-1:0]   pend_pc, pend_nxt;
   logic [31:0]             instr_q, instr_nxt;
   logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_nxt;
   logic                    valid_q, valid_nxt;
   logic                    req_q, req_nxt;
   logic                    fetch_err_q, fetch_err_nxt;
   logic                    misalign_q, misalign_nxt;
   logic                    trap_q, trap_nxt;
   logic [TMO_W-1:0]        tmo_cnt, tmo_nxt;
   logic                    tmo_tc;
   logic [ADDR_WIDTH-1:0]   redir_tgt;
   logic                    redir_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign redir_tgt = redirect_pc;
   assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
   // Without the trap the low bits are simply dropped; the trap flops below
   // never set and reduce to constant 0.
   assign redir_tgt = redirect_pc & ~ADDR_WIDTH'(3);
   assign redir_bad = 1'b0;
`endif

   // Down-counter loaded on entry to REQ/FLUSH; reaching 1 on an unacked
   // cycle means this is the TIMEOUT_CYCLES-th cycle without ack.
   assign tmo_tc = (tmo_cnt == TMO_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         pend_pc     <= RESET_PC;
         instr_q     <= NOP;
         instr_pc_q  <= '0;
         valid_q     <= 1'b0;
         req_q       <= 1'b0;
         fetch_err_q <= 1'b0;
         misalign_q  <= 1'b0;
         trap_q      <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         pend_pc     <= pend_nxt;
         instr_q     <= instr_nxt;
         instr_pc_q  <= instr_pc_nxt;
         valid_q     <= valid_nxt;
         req_q       <= req_nxt;
         fetch_err_q <= fetch_err_nxt;
         misalign_q  <= misalign_nxt;
         trap_q      <= trap_nxt;
         tmo_cnt     <= tmo_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      pend_nxt      = pend_pc;
      instr_nxt     = instr_q;
      instr_pc_nxt  = instr_pc_q;
      valid_nxt     = valid_q;
      fetch_err_nxt = fetch_err_q;
      misalign_nxt  = misalign_q;
      trap_nxt      = trap_q;
      req_nxt       = 1'b0;
      tmo_nxt       = '0;

      case (state)
         ST_IDLE: begin
            state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (imem_ack) begin
               if (redirect_valid) begin
                  pc_nxt       = redir_tgt;
                  misalign_nxt = misalign_q | redir_bad;
                  state_nxt    = redir_bad ? ST_ERR : ST_IDLE;
               end else begin
                  instr_nxt    = imem_rdata;
                  instr_pc_nxt = pc;
                  valid_nxt    = 1'b1;
                  pc_nxt       = pc + ADDR_WIDTH'(4);
                  state_nxt    = ST_HOLD;
               end
            end else if (tmo_tc) begin
               fetch_err_nxt = 1'b1;
               state_nxt     = ST_ERR;
            end else if (redirect_valid) begin
               pend_nxt     = redir_tgt;
               trap_nxt     = redir_bad;
               misalign_nxt = misalign_q | redir_bad;
               state_nxt    = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (imem_ack) begin
               // A redirect arriving with the ack is the newest target.
               misalign_nxt = misalign_q | redir_bad;
               if (trap_q || redir_bad) begin
                  state_nxt = ST_ERR;
               end else begin
                  pc_nxt    = redirect_valid ? redir_tgt : pend_pc;
                  state_nxt = ST_IDLE;
               end
            end else if (tmo_tc) begin
               fetch_err_nxt = 1'b1;
               state_nxt     = ST_ERR;
            end else if (redirect_valid) begin
               pend_nxt     = redir_tgt;
               trap_nxt     = trap_q | redir_bad;
               misalign_nxt = misalign_q | redir_bad;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               valid_nxt = 1'b0;
               if (redir_bad) begin
                  misalign_nxt = 1'b1;
                  state_nxt    = ST_ERR;
               end else begin
                  pc_nxt    = redir_tgt;
                  state_nxt = ST_REQ;
               end
            end else if (instr_ready) begin
               valid_nxt = 1'b0;
               state_nxt = ST_REQ;
            end
         end
         ST_ERR: begin
            state_nxt = ST_ERR;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      req_nxt = (state_nxt == ST_REQ) || (state_nxt == ST_FLUSH);

      // Only an unacked cycle can stay in REQ/FLUSH, so staying means count.
      if (req_nxt) begin
         if (state_nxt != state) begin
            tmo_nxt = TMO_LOAD;
         end else begin
            tmo_nxt = tmo_cnt - TMO_W'(1);
         end
      end
   end

   // pc is held stable for the whole of REQ/FLUSH, so it is the address.
   assign imem_req     = req_q;
   assign imem_addr    = pc;
   assign instr_valid  = valid_q;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign fetch_err    = fetch_err_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   localparam int AW  = 32;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_rdata;
   logic          instr_valid;
   logic          instr_ready;
   logic [31:0]   instr;
   logic [AW-1:0] instr_pc;
   logic          fetch_err;
   logic          misalign_err;

   int n_chk = 0;
   int n_err = 0;

   bit mem_en;
   int mem_wait;
   int wait_cnt;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_WIDTH     (AW),
      .RESET_PC       (32'h0000_0000),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .fetch_err      (fetch_err),
      .misalign_err   (misalign_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance to the next falling edge; redirect is a one-cycle pulse, and the
   // memory answers a request after mem_wait cycles with 0xC0DE_<addr[15:0]>.
   task automatic tick();
      @(negedge clk);
      redirect_valid = 1'b0;
      if (mem_en && imem_req) begin
         if (wait_cnt >= mem_wait) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hC0DE_0000 | {16'h0000, imem_addr[15:0]};
            wait_cnt   = 0;
         end else begin
            imem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         imem_ack = 1'b0;
         wait_cnt = 0;
      end
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
   endtask

   task automatic check_req(input string tag, input logic [31:0] addr);
      check_eq({tag, "_req"}, imem_req, 1);
      check_eq({tag, "_addr"}, imem_addr, addr);
   endtask

   task automatic check_instr(input string tag, input logic [31:0] pc, input logic [31:0] word);
      check_eq({tag, "_valid"}, instr_valid, 1);
      check_eq({tag, "_pc"}, instr_pc, pc);
      check_eq({tag, "_instr"}, instr, word);
      check_eq({tag, "_noreq"}, imem_req, 0);
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_ack       = 1'b0;
      imem_rdata     = '0;
      instr_ready    = 1'b0;
      mem_en         = 1'b1;
      mem_wait       = 0;
      wait_cnt       = 0;

      repeat (2) tick();
      check_eq("rst_req", imem_req, 0);
      check_eq("rst_addr", imem_addr, 32'h0);
      check_eq("rst_valid", instr_valid, 0);
      check_eq("rst_instr", instr, 32'h0000_0013);
      check_eq("rst_instr_pc", instr_pc, 32'h0);
      check_eq("rst_fetch_err", fetch_err, 0);
      check_eq("rst_misalign", misalign_err, 0);

      // sequential fetch, 0-wait memory, decode always ready
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      tick(); check_req("first_req", 32'h0);
      tick(); check_instr("seq0", 32'h0, 32'hC0DE_0000);
      tick(); check_req("seq1_req", 32'h4);
      tick(); check_instr("seq1", 32'h4, 32'hC0DE_0004);
      tick(); check_req("seq2_req", 32'h8);
      tick(); check_instr("seq2", 32'h8, 32'hC0DE_0008);

      // backpressure: hold for 5 cycles
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_instr("bp", 32'h8, 32'hC0DE_0008);
      end
      instr_ready = 1'b1;
      tick(); check_req("bp_next", 32'hC);
      tick(); check_instr("seq3", 32'hC, 32'hC0DE_000C);

      // redirect while a slow request is outstanding
      mem_wait = 3;
      tick(); check_req("slow_req", 32'h10);
      redirect(32'h100);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_req("flush_hold", 32'h10);
         check_eq("flush_valid", instr_valid, 0);
      end
      tick();
      check_eq("flush_drop_valid", instr_valid, 0);
      check_eq("flush_drop_req", imem_req, 0);
      mem_wait = 0;
      tick(); check_req("flush_tgt", 32'h100);
      tick(); check_instr("tgt100", 32'h100, 32'hC0DE_0100);

      // redirect coincident with ack
      tick(); check_req("coin_req", 32'h104);
      redirect(32'h200);
      tick();
      check_eq("coin_valid", instr_valid, 0);
      check_eq("coin_idle", imem_req, 0);
      tick();
      check_req("coin_tgt", 32'h200);
      check_eq("coin_valid2", instr_valid, 0);
      tick(); check_instr("tgt200", 32'h200, 32'hC0DE_0200);

      // redirect in HOLD together with ready
      redirect(32'h300);
      tick();
      check_eq("hold_redir_valid", instr_valid, 0);
      check_req("hold_redir", 32'h300);
      tick(); check_instr("tgt300", 32'h300, 32'hC0DE_0300);

      // pc wrap
      redirect(32'hFFFF_FFFC);
      tick(); check_req("wrap_top", 32'hFFFF_FFFC);
      tick(); check_instr("top", 32'hFFFF_FFFC, 32'hC0DE_FFFC);
      tick(); check_req("wrap_zero", 32'h0);
      tick(); check_instr("wrap0", 32'h0, 32'hC0DE_0000);

      // misaligned redirect
      redirect(32'h102);
      tick();
`ifdef FETCH_MISALIGN_TRAP_EN
      check_eq("mis_err", misalign_err, 1);
      check_eq("mis_noreq", imem_req, 0);
      check_eq("mis_valid", instr_valid, 0);
      tick();
      check_eq("mis_err_sticky", misalign_err, 1);
      check_eq("mis_noreq2", imem_req, 0);
`else
      check_eq("mis_err", misalign_err, 0);
      check_req("mis_align", 32'h100);
      tick();
      check_instr("mis_fetch", 32'h100, 32'hC0DE_0100);
      check_eq("mis_err2", misalign_err, 0);
`endif

      // reset asserted mid-transaction
      mem_wait = 5;
      tick();
`ifndef FETCH_MISALIGN_TRAP_EN
      check_req("mid_req", 32'h104);
`endif
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_req", imem_req, 0);
      check_eq("arst_addr", imem_addr, 32'h0);
      check_eq("arst_valid", instr_valid, 0);
      check_eq("arst_instr", instr, 32'h0000_0013);
      check_eq("arst_misalign", misalign_err, 0);

      // late ack arriving in IDLE is ignored; then memory goes silent
      mem_en = 1'b0;
      tick();
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      rst_n      = 1'b1;
      tick();
      check_req("late_ack", 32'h0);
      check_eq("late_ack_valid", instr_valid, 0);
      check_eq("late_ack_instr", instr, 32'h0000_0013);

      // timeout: 16 unacked request cycles
      repeat (TMO - 1) tick();
      check_eq("tmo_pre_req", imem_req, 1);
      check_eq("tmo_pre_err", fetch_err, 0);
      tick();
      check_eq("tmo_err", fetch_err, 1);
      check_eq("tmo_noreq", imem_req, 0);
      redirect(32'h40);
      mem_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_eq("err_noreq", imem_req, 0);
         check_eq("err_sticky", fetch_err, 1);
         check_eq("err_valid", instr_valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
